// File: rtl/alu_wb_ctrl_pkg.sv
// Shared definitions for the ALU write-back sequencer: default widths, FSM
// state encodings and the ALU operation codes agreed with the ALU.
package alu_wb_ctrl_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_OP_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    localparam logic [DEF_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [DEF_OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [DEF_OP_W-1:0] OP_AND = 3'd2;
    localparam logic [DEF_OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [DEF_OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [DEF_OP_W-1:0] OP_SLT = 3'd5;
    localparam logic [DEF_OP_W-1:0] OP_SLL = 3'd6;
    localparam logic [DEF_OP_W-1:0] OP_SRL = 3'd7;

    // r0 is hard-wired zero, so it is never a legal write target.
    function automatic logic rd_writable(input logic [DEF_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/alu_wb_ctrl_if.sv
// Request, register-file and ALU signals of the write-back sequencer.
// slave = the sequencer; master = the surrounding datapath/requester.
interface alu_wb_ctrl_if #(
    parameter int ADDR_W = alu_wb_ctrl_pkg::DEF_ADDR_W,
    parameter int DATA_W = alu_wb_ctrl_pkg::DEF_DATA_W,
    parameter int OP_W   = alu_wb_ctrl_pkg::DEF_OP_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [ADDR_W-1:0] req_rd;
    logic [ADDR_W-1:0] req_rs;
    logic [ADDR_W-1:0] req_rt;

    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;

    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_f;
    logic              alu_zf;
    logic              alu_of;

    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              write_reg;

    logic              zf;
    logic              of;
    logic              done;

    modport slave (
        input  req_valid, req_op, req_rd, req_rs, req_rt,
        input  alu_f, alu_zf, alu_of,
        output req_ready, r_addr_a, r_addr_b, alu_op,
        output w_addr, w_data, write_reg, zf, of, done
    );

    modport master (
        output req_valid, req_op, req_rd, req_rs, req_rt,
        output alu_f, alu_zf, alu_of,
        input  req_ready, r_addr_a, r_addr_b, alu_op,
        input  w_addr, w_data, write_reg, zf, of, done
    );

endinterface

// File: rtl/alu_wb_ctrl.sv
// Four-state sequencer: accept request, let operands settle through the
// register file and ALU, capture the result, then write it back.
module alu_wb_ctrl
    import alu_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_wb_ctrl_if.slave  bus
);

    state_e            state;
    state_e            state_nxt;
    logic              accept;

    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] r_addr_a_q;
    logic [ADDR_W-1:0] r_addr_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic              write_reg_q;
    logic              done_q;
    logic              zf_res;
    logic              of_res;
    logic              zf_q;
    logic              of_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q        <= '0;
            r_addr_a_q  <= '0;
            r_addr_b_q  <= '0;
            alu_op_q    <= '0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            write_reg_q <= 1'b0;
            done_q      <= 1'b0;
            zf_res      <= 1'b0;
            of_res      <= 1'b0;
            zf_q        <= 1'b0;
            of_q        <= 1'b0;
        end else begin
            // Read addresses and op hold until the next acceptance.
            if (accept) begin
                r_addr_a_q <= bus.req_rs;
                r_addr_b_q <= bus.req_rt;
                alu_op_q   <= bus.req_op;
                rd_q       <= bus.req_rd;
            end
            if (state == S_EXEC) begin
                w_data_q    <= bus.alu_f;
                w_addr_q    <= rd_q;
                write_reg_q <= rd_writable(rd_q);
                done_q      <= 1'b1;
                zf_res      <= bus.alu_zf;
                of_res      <= bus.alu_of;
            end
            // Flags become visible as the register file commits the result.
            if (state == S_WB) begin
                zf_q        <= zf_res;
                of_q        <= of_res;
                write_reg_q <= 1'b0;
                done_q      <= 1'b0;
            end
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.r_addr_a  = r_addr_a_q;
    assign bus.r_addr_b  = r_addr_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.write_reg = write_reg_q;
    assign bus.done      = done_q;
    assign bus.zf        = zf_q;
    assign bus.of        = of_q;

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Scoreboard bench: register file and ALU models wrapped around the
// sequencer, directed requests with hand-computed results.
module tb_alu_wb_ctrl;
    import alu_wb_ctrl_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int OW = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          wen;
        logic          zf;
        logic          of;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   done_cyc[$];

    alu_wb_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .OP_W(OW)) bus ();

    alu_wb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .OP_W(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file: combinational read, write on rising edge.
    logic [DW-1:0] rf [32];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    always @(posedge clk) begin
        if (ld_en) rf[ld_addr] <= ld_data;
        else if (bus.write_reg) rf[bus.w_addr] <= bus.w_data;
    end

    // Combinational ALU.
    logic [DW-1:0] opa, opb, alu_res;
    logic          alu_ovf;
    always_comb begin
        opa     = rf[bus.r_addr_a];
        opb     = rf[bus.r_addr_b];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                alu_res = opa + opb;
                alu_ovf = (opa[DW-1] == opb[DW-1]) && (alu_res[DW-1] != opa[DW-1]);
            end
            OP_SUB: begin
                alu_res = opa - opb;
                alu_ovf = (opa[DW-1] != opb[DW-1]) && (alu_res[DW-1] != opa[DW-1]);
            end
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            default: alu_res = '0;
        endcase
    end
    assign bus.alu_f  = alu_res;
    assign bus.alu_zf = (alu_res == '0);
    assign bus.alu_of = alu_ovf;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compares write-back on the Done cycle, then the flag update
    // and the end of the pulse one cycle later.
    initial begin : monitor
        exp_t cur;
        logic pend = 1'b0;
        logic pzf = 1'b0;
        logic pof = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                pzf  = 1'b0;
                pof  = 1'b0;
            end else begin
                if (pend) begin
                    chk("flag_zf", bus.zf, cur.zf);
                    chk("flag_of", bus.of, cur.of);
                    chk("done_one_cycle", bus.done, 0);
                    chk("wreg_one_cycle", bus.write_reg, 0);
                    pzf  = cur.zf;
                    pof  = cur.of;
                    pend = 1'b0;
                end
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        cur = sb.pop_front();
                        chk("w_addr", bus.w_addr, cur.addr);
                        chk("w_data", bus.w_data, cur.data);
                        chk("write_reg", bus.write_reg, cur.wen);
                        chk("zf_held_until_commit", bus.zf, pzf);
                        chk("of_held_until_commit", bus.of, pof);
                        done_cyc.push_back(cyc);
                        pend = 1'b1;
                    end
                end
                if (bus.write_reg && !bus.done) chk("wreg_only_with_done", bus.done, 1);
            end
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [DW-1:0] exp_data, input logic exp_zf,
                         input logic exp_of, input bit keep, output int stall);
        exp_t e;
        @(negedge clk);
        bus.req_op    = op;
        bus.req_rd    = rd;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        bus.req_valid = 1'b1;
        stall = 0;
        while (!bus.req_ready && stall < 20) begin
            stall++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            fail_now("accept_timeout");
            bus.req_valid = 1'b0;
            return;
        end
        e = '{rd, exp_data, (rd != '0), exp_zf, exp_of};
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("r_addr_a", bus.r_addr_a, rs);
        chk("r_addr_b", bus.r_addr_b, rt);
        chk("alu_op", bus.alu_op, op);
        chk("ready_low_after_accept", bus.req_ready, 0);
        // Scramble the request fields: the sequencer must have latched them.
        bus.req_rs = ~rs;
        bus.req_rt = ~rt;
        bus.req_rd = ~rd;
        bus.req_op = ~op;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !bus.req_ready) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) fail_now("idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_r_addr_a"}, bus.r_addr_a, 0);
        chk({tag, "_r_addr_b"}, bus.r_addr_b, 0);
        chk({tag, "_alu_op"}, bus.alu_op, 0);
        chk({tag, "_w_addr"}, bus.w_addr, 0);
        chk({tag, "_w_data"}, bus.w_data, 0);
        chk({tag, "_write_reg"}, bus.write_reg, 0);
        chk({tag, "_zf"}, bus.zf, 0);
        chk({tag, "_of"}, bus.of, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        int s1, s2;
        logic [DW-1:0] init_v;
        bit seen;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_rd    = '0;
        bus.req_rs    = '0;
        bus.req_rt    = '0;
        rst_n = 1'b0;

        for (int i = 0; i < 32; i++) begin
            case (i)
                1:       init_v = 32'd5;
                2:       init_v = 32'd7;
                4, 5:    init_v = 32'd9;
                6:       init_v = 32'hDEAD_BEEF;
                7:       init_v = 32'h7FFF_FFFF;
                8:       init_v = 32'd1;
                default: init_v = 32'd0;
            endcase
            load(i[AW-1:0], init_v);
        end
        check_all_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus.req_ready, 1);

        issue(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd12, 1'b0, 1'b0, 1'b0, s1);
        wait_idle();
        chk("rf_r3_add", rf[3], 32'd12);

        issue(OP_SUB, 5'd6, 5'd4, 5'd5, 32'd0, 1'b1, 1'b0, 1'b0, s1);
        wait_idle();
        chk("rf_r6_zero", rf[6], 32'd0);

        issue(OP_ADD, 5'd9, 5'd7, 5'd8, 32'h8000_0000, 1'b0, 1'b1, 1'b0, s1);
        wait_idle();
        chk("rf_r9_ovf", rf[9], 32'h8000_0000);

        issue(OP_ADD, 5'd0, 5'd1, 5'd2, 32'd12, 1'b0, 1'b0, 1'b0, s1);
        wait_idle();
        chk("rf_r0_zero", rf[0], 32'd0);

        // Back-to-back dependent pair with Req_Valid held high.
        load(5'd3, 32'd0);
        issue(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd12, 1'b0, 1'b0, 1'b1, s1);
        issue(OP_ADD, 5'd10, 5'd3, 5'd3, 32'd24, 1'b0, 1'b0, 1'b0, s2);
        chk("b2b_ready_low_cycles", s2, 3);
        wait_idle();
        chk("rf_r3_b2b", rf[3], 32'd12);
        chk("rf_r10_b2b", rf[10], 32'd24);
        if (done_cyc.size() >= 2)
            chk("b2b_done_spacing", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 4);
        else
            fail_now("b2b_done_count");

        // Reset during write-back aborts the commit.
        issue(OP_ADD, 5'd11, 5'd1, 5'd2, 32'd12, 1'b0, 1'b0, 1'b0, s1);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.write_reg) seen = 1'b1;
        end
        if (!seen) fail_now("wb_not_reached");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", bus.req_ready, 1);
        chk("rf_r11_unchanged", rf[11], 32'd0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_wb_ctrl.md
Name: alu_wb_ctrl

Overview:
Sequencer closing the loop between the register file and the ALU: accepts one operation request, drives the register-file read addresses and ALU_OP, captures the ALU result and flags, then writes the result back to the destination register through the register-file write port. It is the write-back end of the datapath whose read side feeds the ALU operands. One operation is in flight at a time; throughput is 1 op per 4 cycles.

Parameters:
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, data/result width
OP_W, 3, ALU operation code width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Req_Valid  in  1  request present
Req_Ready  out  1  controller can accept a request
Req_Op  in  OP_W  ALU operation
Req_Rd  in  ADDR_W  destination register
Req_Rs  in  ADDR_W  operand A register
Req_Rt  in  ADDR_W  operand B register
R_Addr_A  out  ADDR_W  register-file read address A
R_Addr_B  out  ADDR_W  register-file read address B
ALU_OP  out  OP_W  operation to ALU
ALU_F  in  DATA_W  ALU result
ALU_ZF  in  1  ALU zero flag
ALU_OF  in  1  ALU overflow flag
W_Addr  out  ADDR_W  register-file write address
W_Data  out  DATA_W  register-file write data
Write_Reg  out  1  register-file write enable
ZF  out  1  registered zero flag of last completed op
OF  out  1  registered overflow flag of last completed op
Done  out  1  one-cycle pulse when an op completes

Behaviour:
- Reset (async, Reset=0): state IDLE; R_Addr_A/B, ALU_OP, W_Addr, W_Data = 0; Write_Reg, ZF, OF, Done = 0. Req_Ready = 1 once in IDLE. Reset mid-operation aborts the op; no write occurs, Write_Reg falls immediately.
- States: IDLE -> READ -> EXEC -> WB -> IDLE; unused encodings go to IDLE.
- IDLE: Req_Ready=1 (decoded from state). Handshake on Req_Valid & Req_Ready at edge T: latch Op, Rd, Rs, Rt; R_Addr_A=Rs, R_Addr_B=Rt, ALU_OP=Op registered at T; -> READ. Request fields need be stable only at the accepting edge.
- READ (cycle after T): operands settle through register file and combinational ALU; -> EXEC. Req_Ready=0.
- EXEC: at edge T+2 capture ALU_F into W_Data, ALU_ZF/ALU_OF into internal result regs, W_Addr=Rd, Write_Reg=1 (registered), Done=1; -> WB.
- WB: Write_Reg=1 for exactly this cycle; register file commits at edge T+3. At edge T+3 ZF/OF update from captured flags, Write_Reg=0, Done=0; -> IDLE.
- R_Addr_A/B and ALU_OP hold their values from acceptance until next acceptance.
- Rd=0: Write_Reg stays 0 (r0 is read-only zero); flags still update; Done still pulses.
- Req_Valid outside IDLE is ignored (no ready); no queueing.
- Dependent back-to-back ops are hazard-free: write commits before the next op's READ.
- ALU_OP values are passed through unchecked; the ALU defines their meaning.
- ZF/OF hold between ops; W_Data/W_Addr hold last value after WB.

Decomposition:
- Shared package: ADDR_W/DATA_W/OP_W defaults, FSM state encodings (IDLE, READ, EXEC, WB), ALU op code constants (ADD, SUB, AND, OR, ...) shared with the ALU.
- Single module; no sub-module is natural. Bench instantiates register file + ALU around it.

Test Plan:
- Reset: assert Reset=0 during WB state -> Write_Reg=0 asynchronously, register unchanged, Req_Ready=1 after release, all outputs 0.
- ADD: r1=5, r2=7; request ADD Rd=3 Rs=1 Rt=2 -> R_Addr_A=1, R_Addr_B=2 from T; Write_Reg high one cycle, W_Addr=3, W_Data=12; Done one pulse; r3=12; ZF=0, OF=0.
- Zero: r4=r5=0x0000_0009, SUB Rd=6 -> W_Data=0, r6=0, ZF=1, OF=0.
- Overflow: r7=0x7FFF_FFFF, r8=1, ADD Rd=9 -> W_Data=0x8000_0000, OF=1, ZF=0.
- Rd=0: ADD r1,r2 into r0 -> Write_Reg never high, r0 stays 0, Done pulses, ZF/OF updated.
- Back-to-back dependent: Req_Valid held high; op1 ADD r3=r1+r2 (12), op2 ADD r10=r3+r3 -> Req_Ready low 3 cycles, op2 accepted in first IDLE cycle, r10=24, two Done pulses 4 cycles apart.
